seq_divider_8by4: RTL and testbench

SEQ_DIVIDER_8BY4 -- requirements
Module: seq_divider_8by4

---
 rtl/seq_divider_8by4_pkg.sv | 13 +
 rtl/seq_divider_8by4_if.sv | 29 ++
 rtl/seq_divider_8by4_div_step.sv | 23 ++
 rtl/seq_divider_8by4.sv | 113 +++++++++++
 tb/tb_seq_divider_8by4.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/seq_divider_8by4_pkg.sv
// Shared widths and FSM state encoding for the sequential 8-by-4 restoring divider.
package vedic_pkg;

    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_8by4_if.sv
// Operand/result handshake bundle for seq_divider_8by4, plus the FSM state for observation.
interface seq_divider_8by4_if
    import vedic_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
);
    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its payload stable while valid is high and ready is low.
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    div_state_e            state_dbg;

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, state_dbg
    );

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, state_dbg
    );
endinterface

// File: rtl/seq_divider_8by4_div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module div_step
    import vedic_pkg::*;
#(
    parameter int DIVISOR_W = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W-1:0] part_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W-1:0] part_o,
    output logic                 qbit_o
);
    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W-1:0] diff;

    // The remainder after a step is always < divisor, so only the low bits of the difference matter.
    always_comb begin
        shifted = {part_i, bit_i};
        diff    = shifted[DIVISOR_W-1:0] - divisor_i;
        qbit_o  = (shifted >= {1'b0, divisor_i});
        part_o  = qbit_o ? diff : shifted[DIVISOR_W-1:0];
    end
endmodule

// File: rtl/seq_divider_8by4.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_BY_ZERO_FLAG_EN to add the div_by_zero output flag.
module seq_divider_8by4
    import vedic_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_divider_8by4_if.slave   bus
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    output logic                div_by_zero
`endif
);
    localparam int CNT_W = $clog2(DIVIDEND_W);

    div_state_e            state_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVIDEND_W-1:0] dvd_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVISOR_W-1:0]  part_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIVISOR_W-1:0]  part_d;
    logic                  qbit_d;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic                  dbz_q;
`endif

    // dvd_q shifts left each iteration: its MSB feeds the step, quotient bits fill in from the LSB.
    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .part_i    (part_q),
        .bit_i     (dvd_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .part_o    (part_d),
        .qbit_o    (qbit_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            part_q      <= '0;
            cnt_q       <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        dvd_q      <= bus.dividend;
                        dvs_q      <= bus.divisor;
                        part_q     <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (bus.divisor == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quot_q      <= '1;
                            rem_q       <= bus.dividend[DIVISOR_W-1:0];
`ifdef DIV_BY_ZERO_FLAG_EN
                            dbz_q       <= 1'b1;
`endif
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    part_q <= part_d;
                    dvd_q  <= {dvd_q[DIVIDEND_W-2:0], qbit_d};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quot_q      <= {dvd_q[DIVIDEND_W-2:0], qbit_d};
                        rem_q       <= part_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
`ifdef DIV_BY_ZERO_FLAG_EN
                        dbz_q       <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.state_dbg = state_q;
`ifdef DIV_BY_ZERO_FLAG_EN
    assign div_by_zero   = dbz_q;
`endif
endmodule

// File: tb/tb_seq_divider_8by4.sv
// Self-checking bench for seq_divider_8by4: directed cases, backpressure, mid-CALC reset, full sweep.
module tb_seq_divider_8by4;
    import vedic_pkg::*;

    localparam int DW = 8;
    localparam int VW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [DW+VW-1:0] exp_q[$];

    seq_divider_8by4_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus ();
`ifdef DIV_BY_ZERO_FLAG_EN
    logic div_by_zero;
`endif

    seq_divider_8by4 #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef DIV_BY_ZERO_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; divide-by-zero yields all-ones and the dividend's low bits.
    function automatic logic [DW+VW-1:0] model(input int a, input int b);
        if (b == 0) return {DW'((1 << DW) - 1), VW'(a % (1 << VW))};
        return {DW'(a / b), VW'(a % b)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int stall);
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        int lat;
        int wait_n;
        string id;
        id = $sformatf("%0d/%0d", a, b);
        exp_q.push_back(model(int'(a), int'(b)));
        wait_n = 0;
        while (bus.in_ready !== 1'b1 && wait_n < 50) begin
            @(posedge clk); #1; wait_n++;
        end
        check({"in_ready wait ", id}, 32'(wait_n < 50), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor  = VW'($urandom);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        {eq, er} = exp_q.pop_front();
        check({"latency ", id}, 32'(lat), (b == 0) ? 32'd1 : 32'(DW + 1));
        check({"quotient ", id}, 32'(bus.quotient), 32'(eq));
        check({"remainder ", id}, 32'(bus.remainder), 32'(er));
        if (b != 0) begin
            check({"identity ", id}, 32'(bus.quotient) * 32'(b) + 32'(bus.remainder), 32'(a));
            check({"rem<div ", id}, 32'(bus.remainder < b), 32'd1);
        end
`ifdef DIV_BY_ZERO_FLAG_EN
        check({"div_by_zero ", id}, 32'(div_by_zero), 32'(b == 0));
`endif
        for (int k = 0; k < stall; k++) begin
            bus.in_valid = 1'b1;
            bus.dividend = DW'($urandom);
            bus.divisor  = VW'($urandom);
            @(posedge clk); #1;
            check({"stall out_valid ", id}, 32'(bus.out_valid), 32'd1);
            check({"stall in_ready ", id}, 32'(bus.in_ready), 32'd0);
            check({"stall quotient ", id}, 32'(bus.quotient), 32'(eq));
            check({"stall remainder ", id}, 32'(bus.remainder), 32'(er));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({"post out_valid ", id}, 32'(bus.out_valid), 32'd0);
        check({"post in_ready ", id}, 32'(bus.in_ready), 32'd1);
        check({"hold quotient ", id}, 32'(bus.quotient), 32'(eq));
        check({"hold remainder ", id}, 32'(bus.remainder), 32'(er));
    endtask

    initial begin
        int vld_seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst state", 32'(bus.state_dbg), 32'(IDLE));
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst quotient", 32'(bus.quotient), 32'd0);
        check("rst remainder", 32'(bus.remainder), 32'd0);
`ifdef DIV_BY_ZERO_FLAG_EN
        check("rst div_by_zero", 32'(div_by_zero), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-computed expectations.
        run_op(8'd200, 4'd7, 0);
        check("200/7 q", 32'(bus.quotient), 32'd28);
        check("200/7 r", 32'(bus.remainder), 32'd4);
        run_op(8'd255, 4'd1, 1);
        check("255/1 q", 32'(bus.quotient), 32'd255);
        check("255/1 r", 32'(bus.remainder), 32'd0);
        run_op(8'd5, 4'd15, 0);
        check("5/15 q", 32'(bus.quotient), 32'd0);
        check("5/15 r", 32'(bus.remainder), 32'd5);
        run_op(8'd100, 4'd0, 2);
        check("100/0 q", 32'(bus.quotient), 32'hFF);
        check("100/0 r", 32'(bus.remainder), 32'd4);

        // Backpressure: five stalled cycles with junk in_valid pulses.
        run_op(8'd200, 4'd7, 5);

        // Reset during the fourth CALC cycle.
        bus.in_valid = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 4'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid state calc", 32'(bus.state_dbg), 32'(CALC));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid rst state", 32'(bus.state_dbg), 32'(IDLE));
        check("mid rst in_ready", 32'(bus.in_ready), 32'd1);
        check("mid rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid rst quotient", 32'(bus.quotient), 32'd0);
        vld_seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) vld_seen++;
        end
        check("no result after rst", 32'(vld_seen), 32'd0);

        // Exhaustive nonzero-divisor sweep with random consumer stalls.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(DW'(a), VW'(b), int'($urandom_range(0, 2)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
